tcdm_bank_resp: RTL

TCDM_BANK_RESP -- requirements
Module: tcdm_bank_resp

---
 rtl/tcdm_pkg.sv | 17 +
 rtl/tcdm_resp_pipe.sv | 41 ++++
 rtl/tcdm_bank_resp.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tcdm_pkg.sv
// Shared types and byte-merge helpers for the TCDM bank responder.
package tcdm_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_e;

  localparam int unsigned ByteW = 8;

  function automatic logic [ByteW-1:0] merge_byte(input logic [ByteW-1:0] old_b,
                                                  input logic [ByteW-1:0] new_b,
                                                  input logic             en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/tcdm_resp_pipe.sv
// Extra read-latency stages (Depth of them) with synchronous clear.
module tcdm_resp_pipe #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  if (Depth == 0) begin : g_bypass
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = clk_i ^ rst_ni;
    assign valid_o = valid_i;
    assign data_o  = data_i;
  end else begin : g_stages
    logic [Depth-1:0] valid_q;
    logic [Width-1:0] data_q [Depth];

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        valid_q <= '0;
        for (int unsigned i = 0; i < Depth; i++) data_q[i] <= '0;
      end else begin
        valid_q[0] <= valid_i;
        data_q[0]  <= data_i;
        for (int unsigned i = 1; i < Depth; i++) begin
          valid_q[i] <= valid_q[i-1];
          data_q[i]  <= data_q[i-1];
        end
      end
    end

    assign valid_o = valid_q[Depth-1];
    assign data_o  = data_q[Depth-1];
  end

endmodule

// File: rtl/tcdm_bank_resp.sv
// TCDM bank: behavioural word storage with fixed read latency and optional
// read-modify-write handling of partial stores.
module tcdm_bank_resp
  import tcdm_pkg::*;
#(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned NumWords     = 2 ** AddrMemWidth,
  parameter int unsigned RespLat      = 1,
  parameter int unsigned ByteWrite    = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [AddrMemWidth-1:0] add_i,
  input  logic                    wen_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [BeWidth-1:0]      be_i,
  output logic [DataWidth-1:0]    rdata_o
);

  localparam int unsigned IdxW = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [AddrMemWidth:0] NumWordsW = (AddrMemWidth + 1)'(NumWords);

  logic [DataWidth-1:0] mem_q [NumWords];

  state_e               state_q, state_d;
  logic [IdxW-1:0]      rmw_idx_q;
  logic [DataWidth-1:0] rmw_wdata_q, rmw_old_q;
  logic [BeWidth-1:0]   rmw_be_q;
  logic                 rmw_ok_q;
  logic [DataWidth-1:0] rdata_q;

  logic                 xfer_s, in_range_s, be_full_s, be_none_s;
  logic [IdxW-1:0]      idx_s;
  logic [DataWidth-1:0] rd_word_s, merged_s;
  logic                 wr_req_s, wr_en_s;
  logic [IdxW-1:0]      wr_idx_s;
  logic [DataWidth-1:0] wr_data_s;
  logic [BeWidth-1:0]   wr_be_s;
  logic                 pipe_valid_s;
  logic [DataWidth-1:0] pipe_data_s;

  assign gnt_o      = rst_ni & req_i & (state_q == IDLE);
  assign xfer_s     = req_i & gnt_o;
  assign in_range_s = ({1'b0, add_i} < NumWordsW);
  assign idx_s      = add_i[IdxW-1:0];
  assign be_full_s  = &be_i;
  assign be_none_s  = ~|be_i;
  assign rd_word_s  = in_range_s ? mem_q[idx_s] : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (xfer_s && wen_i && (ByteWrite == 0) && !be_full_s && !be_none_s) begin
          state_d = RMW;
        end else begin
          state_d = IDLE;
        end
      end
      RMW:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    merged_s = '0;
    for (int unsigned b = 0; b < BeWidth; b++) begin
      merged_s[b*ByteW +: ByteW] = merge_byte(rmw_old_q[b*ByteW +: ByteW],
                                              rmw_wdata_q[b*ByteW +: ByteW], rmw_be_q[b]);
    end
  end

  // One write port shared by direct stores and the RMW commit.
  always_comb begin
    wr_req_s  = 1'b0;
    wr_idx_s  = idx_s;
    wr_data_s = wdata_i;
    wr_be_s   = '0;
    if (state_q == RMW) begin
      wr_req_s  = rmw_ok_q;
      wr_idx_s  = rmw_idx_q;
      wr_data_s = merged_s;
      wr_be_s   = '1;
    end else if (xfer_s && wen_i && in_range_s) begin
      if (ByteWrite != 0) begin
        wr_req_s = 1'b1;
        wr_be_s  = be_i;
      end else if (be_full_s) begin
        wr_req_s = 1'b1;
        wr_be_s  = '1;
      end else begin
        wr_req_s = 1'b0;
      end
    end else begin
      wr_req_s = 1'b0;
    end
  end

  // Reset kills a pending RMW commit but never touches stored words.
  assign wr_en_s = wr_req_s & rst_ni;

  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int unsigned b = 0; b < BeWidth; b++) begin
        if (wr_be_s[b]) mem_q[wr_idx_s][b*ByteW +: ByteW] <= wr_data_s[b*ByteW +: ByteW];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (xfer_s && wen_i) begin
      rmw_idx_q   <= idx_s;
      rmw_wdata_q <= wdata_i;
      rmw_be_q    <= be_i;
      rmw_old_q   <= rd_word_s;
      rmw_ok_q    <= in_range_s;
    end
  end

  tcdm_resp_pipe #(
    .Width(DataWidth),
    .Depth(RespLat - 1)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid_i(xfer_s & ~wen_i),
    .data_i (rd_word_s),
    .valid_o(pipe_valid_s),
    .data_o (pipe_data_s)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (pipe_valid_s) begin
      rdata_q <= pipe_data_s;
    end
  end

  assign rdata_o = rdata_q;

endmodule
